// File: rtl/subckt_seq_pkg.sv
// rtl/subckt_seq_pkg.sv - shared states, LFSR tap table and counter helpers for the activity sequencer
package subckt_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Feedback masks for {v[N-2:0], ^(v & taps)}; N=4 walks 1,3,7,15,14,13,10,5,11,6,12,9,2,4,8 from seed 1.
  function automatic logic [7:0] lfsr_taps(input int n);
    case (n)
      2:       return 8'b0000_0011;
      3:       return 8'b0000_0101;
      4:       return 8'b0000_1001;
      5:       return 8'b0001_0010;
      6:       return 8'b0010_0001;
      7:       return 8'b0100_0001;
      default: return 8'b1000_1110;
    endcase
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/subckt_activity_sequencer_if.sv
// rtl/subckt_activity_sequencer_if.sv - host handshake, results and sub-circuit stimulus/response bundle
interface subckt_activity_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             cfg_mode;
  logic [N_IN-1:0]  cfg_seed;
  logic [CNT_W-1:0] cfg_len;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] in_toggles;
  logic [CNT_W-1:0] out_toggles;
  logic [CNT_W-1:0] ones_cnt;
  logic [N_IN-1:0]  vec_out;
  logic             sub_out;

  modport master (
    output start, abort, cfg_mode, cfg_seed, cfg_len, res_ready, sub_out,
    input  busy, res_valid, in_toggles, out_toggles, ones_cnt, vec_out
  );

  modport slave (
    input  start, abort, cfg_mode, cfg_seed, cfg_len, res_ready, sub_out,
    output busy, res_valid, in_toggles, out_toggles, ones_cnt, vec_out
  );
endinterface

// File: rtl/subckt_seq_lfsr.sv
// rtl/subckt_seq_lfsr.sv - maximal-length Fibonacci LFSR; a zero seed is replaced by 1
module subckt_seq_lfsr
  import subckt_seq_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [N_IN-1:0] seed,
  input  logic            step,
  output logic [N_IN-1:0] value
);
  localparam logic [N_IN-1:0] TAPS = N_IN'(lfsr_taps(N_IN));

  logic [N_IN-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)      value_d = (seed == '0) ? N_IN'(1) : seed;
    else if (step) value_d = {value_q[N_IN-2:0], ^(value_q & TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/subckt_activity_sequencer.sv
// rtl/subckt_activity_sequencer.sv - drives vectors into a sub-circuit and accumulates its switching activity
module subckt_activity_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst_n,
  subckt_activity_sequencer_if.slave bus
);
  localparam logic [31:0] CNT_MAX     = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0]       state_q, state_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic             mode_q, mode_d, first_q, first_d, last_q, last_d;
  logic [N_IN-1:0]  vec_q, vec_d, prev_q, prev_d;
  logic [CNT_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0] in_q, in_d, out_q, out_d, ones_q, ones_d;
  logic [3:0]       settle_q, settle_d;
  logic             lfsr_load, lfsr_step, last_vec;
  logic [N_IN-1:0]  lfsr_val;

  // The LFSR runs one vector ahead of vec_q, so each load of vec_q also steps it.
  subckt_seq_lfsr #(.N_IN(N_IN)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (bus.cfg_seed),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  assign last_vec = mode_q ? (idx_q == len_q - 1'b1) : (vec_q == '1);

  always_comb begin
    state_d = state_q;  busy_d  = busy_q;  valid_d = valid_q;
    mode_d  = mode_q;   first_d = first_q; last_d  = last_q;
    vec_d   = vec_q;    prev_d  = prev_q;  len_d   = len_q;   idx_d = idx_q;
    in_d    = in_q;     out_d   = out_q;   ones_d  = ones_q;  settle_d = settle_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start && !bus.abort) begin
        mode_d = bus.cfg_mode;  len_d = bus.cfg_len;  lfsr_load = 1'b1;
        in_d = '0;  out_d = '0;  ones_d = '0;  prev_d = '0;  idx_d = '0;
        first_d = 1'b1;  last_d = 1'b0;  busy_d = 1'b1;  state_d = S_LOAD;
      end
      S_LOAD: if (mode_q && len_q == '0) begin
        busy_d = 1'b0;  valid_d = 1'b1;  state_d = S_DONE;
      end else begin
        vec_d = mode_q ? lfsr_val : '0;  lfsr_step = mode_q;
        settle_d = 4'd0;  state_d = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        ones_d = CNT_W'(sat_add(32'(ones_q), 32'(bus.sub_out), CNT_MAX));
        if (!first_q) out_d = CNT_W'(sat_add(32'(out_q), 32'(bus.sub_out != last_q), CNT_MAX));
        in_d = CNT_W'(sat_add(32'(in_q), 32'(popcount(8'(vec_q ^ prev_q))), CNT_MAX));
        prev_d = vec_q;  last_d = bus.sub_out;  first_d = 1'b0;  idx_d = idx_q + 1'b1;
        if (last_vec) begin
          busy_d = 1'b0;  valid_d = 1'b1;  state_d = S_DONE;
        end else begin
          vec_d = mode_q ? lfsr_val : vec_q + 1'b1;  lfsr_step = mode_q;
          settle_d = 4'd0;  state_d = S_SETTLE;
        end
      end
      S_DONE: if (bus.res_ready) begin
        valid_d = 1'b0;  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;  busy_d = 1'b0;  valid_d = 1'b0;  vec_d = '0;  lfsr_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  busy_q  <= 1'b0;  valid_q <= 1'b0;
      mode_q  <= 1'b0;    first_q <= 1'b0;  last_q  <= 1'b0;
      vec_q   <= '0;      prev_q  <= '0;    len_q   <= '0;    idx_q <= '0;
      in_q    <= '0;      out_q   <= '0;    ones_q  <= '0;    settle_q <= 4'd0;
    end else begin
      state_q <= state_d;  busy_q  <= busy_d;  valid_q <= valid_d;
      mode_q  <= mode_d;   first_q <= first_d; last_q  <= last_d;
      vec_q   <= vec_d;    prev_q  <= prev_d;  len_q   <= len_d;   idx_q <= idx_d;
      in_q    <= in_d;     out_q   <= out_d;   ones_q  <= ones_d;  settle_q <= settle_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.res_valid   = valid_q;
  assign bus.vec_out     = vec_q;
  assign bus.in_toggles  = in_q;
  assign bus.out_toggles = out_q;
  assign bus.ones_cnt    = ones_q;
endmodule

// File: tb/tb_subckt_activity_sequencer.sv
// tb/tb_subckt_activity_sequencer.sv - directed table-driven bench for the activity sequencer
module tb_subckt_activity_sequencer;
  typedef struct {
    logic        mode;
    logic [3:0]  seed;
    logic [15:0] len;
    logic [1:0]  fsel;
    int          seq_start;
    int          ones;
    int          otog;
    int          itog;
    int          cycles;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] fsel_a = 2'd0;
  logic [1:0] fsel_b = 2'd0;
  int         n_chk  = 0;
  int         n_fail = 0;
  vec_t       tbl [7];
  logic [3:0] lfsr_seq [15];

  always #5 clk = ~clk;

  subckt_activity_sequencer_if #(.N_IN(4), .CNT_W(16)) ha ();
  subckt_activity_sequencer_if #(.N_IN(4), .CNT_W(3))  hb ();

  subckt_activity_sequencer #(.N_IN(4), .CNT_W(16), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ha));
  subckt_activity_sequencer #(.N_IN(4), .CNT_W(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(hb));

  function automatic logic f_model(input logic [1:0] sel, input logic [3:0] v);
    case (sel)
      2'd0:    return ~v[0] & ~v[1] & (v[2] ~^ v[3]);
      2'd1:    return v[0];
      2'd2:    return v[1];
      default: return v[3];
    endcase
  endfunction

  assign ha.sub_out = f_model(fsel_a, ha.vec_out);
  assign hb.sub_out = f_model(fsel_b, hb.vec_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_a(input vec_t r, input string tag, input bit release_res);
    int         cyc;
    int         nv;
    bit         seen;
    logic [3:0] ev;
    cyc  = 0;
    seen = 1'b0;
    nv   = r.mode ? int'(r.len) : 16;
    fsel_a = r.fsel;
    ha.cfg_mode = r.mode;  ha.cfg_seed = r.seed;  ha.cfg_len = r.len;  ha.start = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      ha.start = 1'b0;
      if (ha.res_valid) seen = 1'b1;
      else begin
        if (cyc == 1) check({tag, " busy"}, 32'(ha.busy), 32'd1);
        if (cyc >= 2 && cyc % 2 == 0 && (cyc - 2) / 2 < nv) begin
          ev = r.mode ? lfsr_seq[(r.seq_start + (cyc - 2) / 2) % 15] : 4'((cyc - 2) / 2);
          check($sformatf("%s vec%0d", tag, (cyc - 2) / 2), 32'(ha.vec_out), 32'(ev));
        end
      end
    end
    check({tag, " latency"}, 32'(cyc), 32'(r.cycles));
    check({tag, " busy_done"}, 32'(ha.busy), 32'd0);
    check({tag, " ones_cnt"}, 32'(ha.ones_cnt), 32'(r.ones));
    check({tag, " out_toggles"}, 32'(ha.out_toggles), 32'(r.otog));
    check({tag, " in_toggles"}, 32'(ha.in_toggles), 32'(r.itog));
    if (release_res) begin
      ha.res_ready = 1'b1;
      @(negedge clk);
      ha.res_ready = 1'b0;
      check({tag, " res_valid_clear"}, 32'(ha.res_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int rises;
    lfsr_seq = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5,
                 4'd11, 4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8};
    //          mode  seed   len     fsel  start ones otog itog cycles
    tbl[0] = '{1'b0, 4'd0, 16'd0,  2'd0, 0,    2,   3,   26,  34};
    tbl[1] = '{1'b0, 4'd0, 16'd0,  2'd1, 0,    8,   15,  26,  34};
    tbl[2] = '{1'b1, 4'd0, 16'd15, 2'd1, 0,    8,   7,   31,  32};
    tbl[3] = '{1'b1, 4'd5, 16'd5,  2'd2, 7,    2,   2,   12,  12};
    tbl[4] = '{1'b1, 4'd8, 16'd1,  2'd3, 14,   1,   0,   1,   4};
    tbl[5] = '{1'b1, 4'd1, 16'd16, 2'd1, 0,    9,   8,   33,  34};
    tbl[6] = '{1'b1, 4'd3, 16'd0,  2'd1, 1,    0,   0,   0,   2};

    ha.start = 1'b0;  ha.abort = 1'b0;  ha.cfg_mode = 1'b0;  ha.cfg_seed = 4'd0;
    ha.cfg_len = 16'd0;  ha.res_ready = 1'b0;
    hb.start = 1'b0;  hb.abort = 1'b0;  hb.cfg_mode = 1'b0;  hb.cfg_seed = 4'd0;
    hb.cfg_len = 3'd0;  hb.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(ha.busy), 32'd0);
    check("reset res_valid", 32'(ha.res_valid), 32'd0);
    check("reset vec_out", 32'(ha.vec_out), 32'd0);
    check("reset counters", {ha.in_toggles, ha.ones_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_a(tbl[i], $sformatf("row%0d", i), 1'b1);

    ha.start = 1'b1;  ha.abort = 1'b1;
    @(negedge clk);
    ha.start = 1'b0;  ha.abort = 1'b0;
    check("idle start+abort busy", 32'(ha.busy), 32'd0);
    @(negedge clk);
    check("idle start+abort still idle", 32'(ha.busy), 32'd0);

    fsel_a = 2'd0;  ha.cfg_mode = 1'b0;  ha.start = 1'b1;
    repeat (11) begin @(negedge clk); ha.start = 1'b0; end
    ha.abort = 1'b1;
    @(negedge clk);
    ha.abort = 1'b0;
    check("abort busy", 32'(ha.busy), 32'd0);
    check("abort vec_out", 32'(ha.vec_out), 32'd0);
    check("abort res_valid", 32'(ha.res_valid), 32'd0);
    rises = 0;
    repeat (40) begin @(negedge clk); if (ha.res_valid) rises++; end
    check("abort no result", 32'(rises), 32'd0);
    run_a(tbl[0], "after_abort", 1'b1);

    run_a(tbl[0], "hold", 1'b0);
    for (int i = 0; i < 10; i++) begin
      ha.start = (i == 3 || i == 6);
      @(negedge clk);
      check($sformatf("hold%0d res_valid", i), 32'(ha.res_valid), 32'd1);
      check($sformatf("hold%0d counters", i),
            {8'(ha.ones_cnt), 8'(ha.out_toggles), 16'(ha.in_toggles)}, {8'd2, 8'd3, 16'd26});
      check($sformatf("hold%0d busy", i), 32'(ha.busy), 32'd0);
    end
    ha.start = 1'b0;  ha.res_ready = 1'b1;
    @(negedge clk);
    ha.res_ready = 1'b0;
    check("release res_valid", 32'(ha.res_valid), 32'd0);
    check("release busy", 32'(ha.busy), 32'd0);
    check("release counters kept", {8'(ha.ones_cnt), 8'(ha.out_toggles), 16'(ha.in_toggles)},
          {8'd2, 8'd3, 16'd26});
    @(negedge clk);
    check("release idle", 32'(ha.busy), 32'd0);

    fsel_b = 2'd1;  hb.cfg_mode = 1'b0;  hb.start = 1'b1;  cyc = 0;
    while (!hb.res_valid && cyc < 200) begin @(negedge clk); cyc++; hb.start = 1'b0; end
    check("sat latency", 32'(cyc), 32'd34);
    check("sat ones_cnt", 32'(hb.ones_cnt), 32'd7);
    check("sat out_toggles", 32'(hb.out_toggles), 32'd7);
    check("sat in_toggles", 32'(hb.in_toggles), 32'd7);
    hb.res_ready = 1'b1;
    @(negedge clk);
    hb.res_ready = 1'b0;

    fsel_a = 2'd0;  ha.cfg_mode = 1'b0;  ha.start = 1'b1;
    repeat (12) begin @(negedge clk); ha.start = 1'b0; end
    check("pre-reset vec_out", 32'(ha.vec_out), 32'd5);
    check("pre-reset in_toggles", 32'(ha.in_toggles), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(ha.busy), 32'd0);
    check("async reset res_valid", 32'(ha.res_valid), 32'd0);
    check("async reset vec_out", 32'(ha.vec_out), 32'd0);
    check("async reset counters", {8'(ha.ones_cnt), 8'(ha.out_toggles), 16'(ha.in_toggles)},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(tbl[6], "len0", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
